// File: rtl/fp_cpl_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fp_cpl_buffer_pkg
//   Shared types and constants for the FP completion buffer: the per-entry
//   record held in the buffer, its reset value, field widths and a small
//   width helper used to size unit indices.
// ---------------------------------------------------------------------------
package fp_cpl_buffer_pkg;

    localparam int RD_W     = 5;   // architectural FP register index
    localparam int RESULT_W = 64;  // FP result width
    localparam int FLAGS_W  = 5;   // NV, DZ, OF, UF, NX

    typedef struct packed {
        logic                valid;  // slot allocated to an in-flight op
        logic                done;   // result has arrived
        logic [RD_W-1:0]     rd;
        logic [RESULT_W-1:0] result;
        logic [FLAGS_W-1:0]  flags;
    } fp_cpl_entry_type;

    parameter fp_cpl_entry_type init_fp_cpl_entry = '0;

    // Index width that stays at least one bit wide for a single unit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_cpl_buffer_if.sv
// ---------------------------------------------------------------------------
// fp_cpl_buffer_if
//   Bundles the issue, completion and writeback channels of the completion
//   buffer.
//   slave  : the buffer side
//   master : the FPU control / functional unit / writeback side
//   Issue      : issue_valid_i, issue_ready_o, issue_rd_i, issue_tag_o
//   Completion : cpl_valid_i, cpl_tag_i, cpl_result_i, cpl_flags_i
//                (unit u occupies slice [u*W +: W] of each packed bus)
//   Writeback  : wb_valid_o, wb_ready_i, wb_rd_o, wb_result_o, wb_flags_o
// ---------------------------------------------------------------------------
interface fp_cpl_buffer_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 3
);
    import fp_cpl_buffer_pkg::*;

    logic                          issue_valid_i;
    logic                          issue_ready_o;
    logic [RD_W-1:0]               issue_rd_i;
    logic [TAG_W-1:0]              issue_tag_o;

    logic [NUM_UNITS-1:0]          cpl_valid_i;
    logic [NUM_UNITS*TAG_W-1:0]    cpl_tag_i;
    logic [NUM_UNITS*RESULT_W-1:0] cpl_result_i;
    logic [NUM_UNITS*FLAGS_W-1:0]  cpl_flags_i;

    logic                          wb_valid_o;
    logic                          wb_ready_i;
    logic [RD_W-1:0]               wb_rd_o;
    logic [RESULT_W-1:0]           wb_result_o;
    logic [FLAGS_W-1:0]            wb_flags_o;

    modport slave (
        input  issue_valid_i, issue_rd_i,
        output issue_ready_o, issue_tag_o,
        input  cpl_valid_i, cpl_tag_i, cpl_result_i, cpl_flags_i,
        output wb_valid_o, wb_rd_o, wb_result_o, wb_flags_o,
        input  wb_ready_i
    );

    modport master (
        output issue_valid_i, issue_rd_i,
        input  issue_ready_o, issue_tag_o,
        output cpl_valid_i, cpl_tag_i, cpl_result_i, cpl_flags_i,
        input  wb_valid_o, wb_rd_o, wb_result_o, wb_flags_o,
        output wb_ready_i
    );

endinterface

// File: rtl/fp_cpl_buffer_wr_arb.sv
// ---------------------------------------------------------------------------
// fp_cpl_wr_arb
//   Completion write arbiter for one buffer entry. Compares every unit's tag
//   against this entry's index and picks the lowest-numbered matching unit.
//   cpl_valid_i  : per-unit completion valid
//   cpl_tag_i    : per-unit tag, unit u at [u*TAG_W +: TAG_W]
//   hit_o        : at least one unit targets this entry
//   win_unit_o   : index of the lowest matching unit
//   multi_hit_o  : two or more units target this entry in the same cycle
// ---------------------------------------------------------------------------
module fp_cpl_wr_arb #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 3,
    parameter int UNIT_W    = 2,
    parameter int ENTRY_IDX = 0
) (
    input  logic [NUM_UNITS-1:0]       cpl_valid_i,
    input  logic [NUM_UNITS*TAG_W-1:0] cpl_tag_i,
    output logic                       hit_o,
    output logic [UNIT_W-1:0]          win_unit_o,
    output logic                       multi_hit_o
);

    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(ENTRY_IDX);

    always_comb begin
        hit_o       = 1'b0;
        win_unit_o  = '0;
        multi_hit_o = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (cpl_valid_i[u] && (cpl_tag_i[u*TAG_W +: TAG_W] == MY_TAG)) begin
                if (hit_o) begin
                    multi_hit_o = 1'b1;
                end else begin
                    hit_o      = 1'b1;
                    win_unit_o = UNIT_W'(u);
                end
            end
        end
    end

endmodule

// File: rtl/fp_cpl_buffer.sv
// ---------------------------------------------------------------------------
// fp_cpl_buffer
//   In-order completion buffer between FPU issue and register writeback.
//   Each issued op gets a tag (the tail slot). Functional units return results
//   out of order by tag; results retire strictly in issue order and their
//   exception flags accumulate into a sticky fflags register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : discard every entry, pointers back to zero
//   flags_clr_i  : clear acc_flags_o (a retire in the same cycle still ORs in)
//   acc_flags_o  : sticky OR of retired flags
//   count_o      : occupied entries
//   err_o        : sticky protocol error (bad / colliding completion)
//   bus          : issue / completion / writeback channels (slave side)
// ---------------------------------------------------------------------------
module fp_cpl_buffer
    import fp_cpl_buffer_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   flags_clr_i,
    output logic [FLAGS_W-1:0]     acc_flags_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   err_o,
    fp_cpl_buffer_if.slave         bus
);

    localparam int TAG_W  = $clog2(DEPTH);
    localparam int UNIT_W = idx_w(NUM_UNITS);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   head_q, tail_q;
    logic [TAG_W-1:0] head_idx, tail_idx;
    fp_cpl_entry_type entry_q [DEPTH];
    fp_cpl_entry_type head_entry;

    logic full;
    logic issue_fire;
    logic retire;

    logic [DEPTH-1:0] hit, multi_hit, cpl_ok, cpl_bad;
    logic [UNIT_W-1:0] win_unit [DEPTH];
    logic [FLAGS_W-1:0] acc_q;
    logic err_q;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    // Issue acceptance looks at registered state only; a retire in the same
    // cycle does not free a slot until the next cycle.
    assign bus.issue_ready_o = !full;
    assign bus.issue_tag_o   = tail_idx;
    assign issue_fire        = bus.issue_valid_i && !full;

    assign head_entry      = entry_q[head_idx];
    assign bus.wb_valid_o  = head_entry.valid && head_entry.done;
    assign bus.wb_rd_o     = head_entry.rd;
    assign bus.wb_result_o = head_entry.result;
    assign bus.wb_flags_o  = head_entry.flags;
    assign retire          = bus.wb_valid_o && bus.wb_ready_i;

    assign count_o     = tail_q - head_q;
    assign acc_flags_o = acc_q;
    assign err_o       = err_q;

    // Per-entry completion arbitration. A completion is only legal to an
    // allocated, not-yet-done slot that is not being (re)issued this cycle.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        fp_cpl_wr_arb #(
            .NUM_UNITS (NUM_UNITS),
            .TAG_W     (TAG_W),
            .UNIT_W    (UNIT_W),
            .ENTRY_IDX (e)
        ) u_arb (
            .cpl_valid_i (bus.cpl_valid_i),
            .cpl_tag_i   (bus.cpl_tag_i),
            .hit_o       (hit[e]),
            .win_unit_o  (win_unit[e]),
            .multi_hit_o (multi_hit[e])
        );

        logic slot_open;
        assign slot_open  = entry_q[e].valid && !entry_q[e].done &&
                            !(issue_fire && (tail_idx == TAG_W'(e)));
        assign cpl_ok[e]  = hit[e] && slot_open;
        assign cpl_bad[e] = (hit[e] && !slot_open) || multi_hit[e];
    end

    // Entry array and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < DEPTH; e++) entry_q[e] <= init_fp_cpl_entry;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < DEPTH; e++) entry_q[e] <= init_fp_cpl_entry;
        end else begin
            head_q <= head_q + (TAG_W+1)'(retire);
            tail_q <= tail_q + (TAG_W+1)'(issue_fire);
            // Retire and issue never touch the same slot: issuing needs a
            // non-full buffer, so tail==head would mean empty (nothing to retire).
            for (int e = 0; e < DEPTH; e++) begin
                if (retire && (head_idx == TAG_W'(e))) begin
                    entry_q[e].valid <= 1'b0;
                end
                if (cpl_ok[e]) begin
                    entry_q[e].done   <= 1'b1;
                    entry_q[e].result <= bus.cpl_result_i[int'(win_unit[e])*RESULT_W +: RESULT_W];
                    entry_q[e].flags  <= bus.cpl_flags_i[int'(win_unit[e])*FLAGS_W +: FLAGS_W];
                end
                if (issue_fire && (tail_idx == TAG_W'(e))) begin
                    entry_q[e].valid <= 1'b1;
                    entry_q[e].done  <= 1'b0;
                    entry_q[e].rd    <= bus.issue_rd_i;
                end
            end
        end
    end

    // Accumulated flags and sticky error. Flush keeps both and suppresses
    // errors from the same-cycle traffic it discards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if (!flush_i) begin
            acc_q <= (flags_clr_i ? '0 : acc_q) | (retire ? bus.wb_flags_o : '0);
            err_q <= err_q || (|cpl_bad);
        end
    end

endmodule
